// File: rtl/drive_pkg.sv
// Shared encodings for the drive output stage: motion command fields and motor FSM states.
package drive_pkg;

  localparam logic [1:0] BF_STOP  = 2'b00;
  localparam logic [1:0] BF_FWD   = 2'b01;
  localparam logic [1:0] BF_REV   = 2'b10;

  localparam logic [1:0] TLR_NONE = 2'b00;
  localparam logic [1:0] TLR_L    = 2'b01;
  localparam logic [1:0] TLR_R    = 2'b10;
  localparam logic [1:0] TLR_HAZ  = 2'b11;

  typedef enum logic [1:0] {
    StIdle,
    StFwd,
    StRev,
    StDead
  } drive_state_e;

endpackage

// File: rtl/tick_divider.sv
// Enabled cycle divider: one-cycle tick on every DIV-th enabled cycle; clr restarts the count.
module tick_divider #(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int unsigned W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] Last = W'(DIV - 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign tick = en & ~clr & (cnt_q == Last);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == Last) ? '0 : cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/drive_output_stage.sv
// Motor/steer drive with reversal dead-time, indicator blinking and a saturating mileage count.
module drive_output_stage
  import drive_pkg::*;
#(
  parameter int unsigned DEAD_CYC   = 5_000_000,
  parameter int unsigned BLINK_HALF = 50_000_000,
  parameter int unsigned MILE_CYC   = 100_000_000,
  parameter int unsigned MILE_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [3:0]        cmd,
  output logic              move_fwd,
  output logic              move_back,
  output logic              turn_left,
  output logic              turn_right,
  output logic              led_left,
  output logic              led_right,
  output logic              moving,
  output logic [MILE_W-1:0] mileage
);

  localparam int unsigned DeadW = (DEAD_CYC > 1) ? $clog2(DEAD_CYC) : 1;
  localparam logic [DeadW-1:0] DeadLast = DeadW'(DEAD_CYC - 1);

  logic [1:0] bf, tlr;
  assign bf  = cmd[1:0];
  assign tlr = cmd[3:2];

  drive_state_e     state_q, state_d;
  drive_state_e     dir_q, dir_d;
  logic [DeadW-1:0] dead_q, dead_d;
  logic             phase_q, phase_d;
  logic             blink_tick, blink_clr, mile_tick;
  logic [MILE_W-1:0] mileage_q;

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    dead_d  = dead_q;
    if (!enable) begin
      state_d = StIdle;
      dead_d  = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bf == BF_FWD) begin
            state_d = StFwd;
          end else if (bf == BF_REV) begin
            state_d = StRev;
          end
        end
        StFwd: begin
          if (bf == BF_REV) begin
            state_d = StDead;
            dir_d   = StRev;
            dead_d  = '0;
          end else if (bf != BF_FWD) begin
            state_d = StIdle;
          end
        end
        StRev: begin
          if (bf == BF_FWD) begin
            state_d = StDead;
            dir_d   = StFwd;
            dead_d  = '0;
          end else if (bf != BF_REV) begin
            state_d = StIdle;
          end
        end
        StDead: begin
          if (bf == BF_FWD || bf == BF_REV) begin
            // A flip mid dead-time retargets the exit but keeps the running count.
            dir_d = (bf == BF_FWD) ? StFwd : StRev;
            if (dead_q == DeadLast) begin
              state_d = dir_d;
              dead_d  = '0;
            end else begin
              dead_d = dead_q + DeadW'(1);
            end
          end else begin
            state_d = StIdle;
            dead_d  = '0;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  assign blink_clr = ~enable;
  assign phase_d   = enable & (phase_q ^ blink_tick);

  tick_divider #(
    .DIV(BLINK_HALF)
  ) u_blink_div (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (blink_clr),
    .en   (enable),
    .tick (blink_tick)
  );

  // Prescaler holds (not cleared) whenever the car is not moving.
  tick_divider #(
    .DIV(MILE_CYC)
  ) u_mile_div (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (1'b0),
    .en   (moving),
    .tick (mile_tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      dir_q      <= StIdle;
      dead_q     <= '0;
      phase_q    <= 1'b0;
      mileage_q  <= '0;
      turn_left  <= 1'b0;
      turn_right <= 1'b0;
      led_left   <= 1'b0;
      led_right  <= 1'b0;
    end else begin
      state_q    <= state_d;
      dir_q      <= dir_d;
      dead_q     <= dead_d;
      phase_q    <= phase_d;
      turn_left  <= enable & (tlr == TLR_L);
      turn_right <= enable & (tlr == TLR_R);
      led_left   <= phase_d & tlr[0];
      led_right  <= phase_d & tlr[1];
      if (mile_tick && (mileage_q != '1)) begin
        mileage_q <= mileage_q + MILE_W'(1);
      end
    end
  end

  assign move_fwd  = (state_q == StFwd);
  assign move_back = (state_q == StRev);
  assign moving    = move_fwd | move_back;
  assign mileage   = mileage_q;

endmodule
